// File: rtl/seg_bus_decoder.sv
// Decoder for a multiplexed 4-digit 7-segment display bus. Waits for each digit
// to hold steady, then publishes all four digits together as one atomic frame.
module seg_bus_decoder #(
  parameter int STABLE_CNT = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  seg_err,
  output logic        anode_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [3:0]       anode_p0, sa, prev_sa;
  logic [6:0]       seg_p0, ss, prev_ss;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]       mask, mask_set;
  logic [15:0]      shadow_code, frame_code;
  logic [3:0]       shadow_err, frame_err;
  logic [1:0]       slot;
  logic [4:0]       dec;
  logic             sa_valid, sa_blank, sa_illegal;
  logic             changed, at_stable, capture, frame_full;

  // Returns {error, code}; blank is a legal code, not an error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      7'b1111111: return 5'h0F;
      default:    return 5'h1E;
    endcase
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] a);
    case (a)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Stage p0 -> sa/ss: two-flop synchronizers, idle (all ones) in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_p0 <= 4'hF;
      sa       <= 4'hF;
      seg_p0   <= 7'h7F;
      ss       <= 7'h7F;
      prev_sa  <= 4'hF;
      prev_ss  <= 7'h7F;
    end else begin
      anode_p0 <= anode;
      sa       <= anode_p0;
      seg_p0   <= seg;
      ss       <= seg_p0;
      prev_sa  <= sa;
      prev_ss  <= ss;
    end
  end

  assign sa_valid   = (sa == 4'b1110) || (sa == 4'b1101) ||
                      (sa == 4'b1011) || (sa == 4'b0111);
  assign sa_blank   = (sa == 4'b1111);
  assign sa_illegal = !sa_valid && !sa_blank;
  assign changed    = ({sa, ss} != {prev_sa, prev_ss});
  assign cnt_inc    = cnt + 1'b1;
  assign at_stable  = (cnt_inc == CNT_W'(STABLE_CNT));
  assign slot       = anode_index(sa);
  assign dec        = decode_seg(ss);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Any non-valid anode (blank or illegal) aborts counting, so an illegal
  // value landing on the would-be capture cycle suppresses the capture.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (sa_valid) begin
          state_next = COUNT;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next   = '0;
        end
      end
      COUNT: begin
        if (!sa_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (changed) begin
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next   = cnt_inc;
          if (at_stable) begin
            capture    = 1'b1;
            state_next = HELD;
          end
        end
      end
      HELD: begin
        if (!sa_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (changed) begin
          state_next = COUNT;
          cnt_next   = CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Shadow contents with the digit being captured this cycle merged in, so a
  // completing capture publishes its own digit in the same edge.
  always_comb begin
    frame_code = shadow_code;
    frame_err  = shadow_err;
    if (capture) begin
      frame_code[{slot, 2'b00} +: 4] = dec[3:0];
      frame_err[slot]                = dec[4];
    end
  end

  assign mask_set   = mask | (4'b0001 << slot);
  assign frame_full = capture && (mask_set == 4'hF);

  // Capture stage -> published frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask        <= 4'h0;
      shadow_code <= 16'h0000;
      shadow_err  <= 4'h0;
      digits      <= 16'h0000;
      seg_err     <= 4'h0;
      frame_valid <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      anode_err   <= sa_illegal;
      frame_valid <= frame_full;
      if (capture) begin
        shadow_code <= frame_code;
        shadow_err  <= frame_err;
        mask        <= frame_full ? 4'h0 : mask_set;
      end
      if (frame_full) begin
        digits  <= frame_code;
        seg_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_seg_bus_decoder.sv
// Bench for seg_bus_decoder: directed scan scenarios plus randomized bus
// traffic, all compared against a run-length reference model of the bus.
module tb_seg_bus_decoder;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  seg_err;
  logic        anode_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  seg_bus_decoder #(.STABLE_CNT(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .anode(anode), .seg(seg),
    .digits(digits), .frame_valid(frame_valid), .seg_err(seg_err), .anode_err(anode_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (pat(d) == s) return {1'b0, 4'(d)};
    if (s == 7'h7F) return 5'h0F;
    return 5'h1E;
  endfunction

  function automatic logic [27:0] segs4(input int d0, input int d1, input int d2, input int d3);
    return {pat(d3), pat(d2), pat(d1), pat(d0)};
  endfunction

  // Reference model: the bus as seen two cycles late; a digit is taken when
  // its run of identical valid samples reaches exactly SC.
  typedef struct packed {
    logic [10:0] d1, d2, last;
    int          run;
    logic [3:0]  mask;
    logic [15:0] code;
    logic [3:0]  err;
    logic [15:0] digits;
    logic [3:0]  seg_err;
    logic        fv, aerr;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    m.d1 = 11'h7FF; m.d2 = 11'h7FF; m.last = 11'h7FF;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [10:0] in);
    model_t n;
    logic [3:0] a;
    int zeros, idx;
    logic [4:0] d;
    n = m;
    a = m.d2[10:7];
    zeros = $countones(~a);
    n.aerr = (a != 4'hF) && (zeros != 1);
    n.fv = 1'b0;
    if (zeros == 1) n.run = (m.run > 0 && m.d2 == m.last) ? m.run + 1 : 1;
    else n.run = 0;
    n.last = m.d2;
    if (n.run == SC) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      d = model_decode(m.d2[6:0]);
      n.code[idx*4 +: 4] = d[3:0];
      n.err[idx] = d[4];
      n.mask = m.mask | (4'b0001 << idx);
      if (n.mask == 4'hF) begin
        n.digits = n.code; n.seg_err = n.err; n.fv = 1'b1; n.mask = 4'h0;
      end
    end
    n.d2 = m.d1;
    n.d1 = in;
    return n;
  endfunction

  model_t m = model_reset();
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, {anode, seg});
  end

  int fv_cnt = 0, exp_fv_cnt = 0, aerr_cnt = 0, exp_aerr_cnt = 0, bad_cyc = 0, last_fv_cyc = -1;
  always @(negedge clk) begin
    if (frame_valid) begin fv_cnt <= fv_cnt + 1; last_fv_cyc <= cyc; end
    if (m.fv) exp_fv_cnt <= exp_fv_cnt + 1;
    if (anode_err) aerr_cnt <= aerr_cnt + 1;
    if (m.aerr) exp_aerr_cnt <= exp_aerr_cnt + 1;
    if ({digits, seg_err, frame_valid, anode_err} !== {m.digits, m.seg_err, m.fv, m.aerr})
      bad_cyc <= bad_cyc + 1;
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    anode = a; seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] segs, input int dwell, input int ndig,
                      input int flush, output int last_start);
    logic [3:0] a;
    last_start = cyc;
    for (int i = 0; i < ndig; i++) begin
      a = 4'hF; a[i] = 1'b0;
      last_start = cyc;
      drive(a, segs[7*i +: 7], dwell);
    end
    if (flush > 0) drive(4'hF, 7'h7F, flush);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want 0000", digits); end
    tests++; if (seg_err !== 4'h0) begin fails++; $display("FAIL reset_seg_err: got %h want 0", seg_err); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    tests++; if (anode_err !== 1'b0) begin fails++; $display("FAIL reset_aerr: got %b want 0", anode_err); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scan_basic();
    int f0, a0, b0, t;
    f0 = fv_cnt; a0 = aerr_cnt; b0 = bad_cyc;
    scan(segs4(1, 2, 3, 4), 8, 4, 6, t);
    tests++; if (fv_cnt - f0 !== 1) begin fails++; $display("FAIL basic_frames: got %0d want 1", fv_cnt - f0); end
    tests++; if (digits !== 16'h4321) begin fails++; $display("FAIL basic_digits: got %h want 4321", digits); end
    tests++; if (seg_err !== 4'h0) begin fails++; $display("FAIL basic_seg_err: got %h want 0", seg_err); end
    tests++; if (aerr_cnt !== a0) begin fails++; $display("FAIL basic_aerr: got %0d pulses want 0", aerr_cnt - a0); end
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL basic_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
  endtask

  task automatic test_dwell();
    int f0, b0, t;
    f0 = fv_cnt; b0 = bad_cyc;
    scan(segs4(9, 8, 7, 6), SC - 1, 4, 8, t);
    tests++; if (fv_cnt !== f0) begin fails++; $display("FAIL short_dwell_frames: got %0d want 0", fv_cnt - f0); end
    tests++; if (digits !== 16'h4321) begin fails++; $display("FAIL short_dwell_hold: got %h want 4321", digits); end
    f0 = fv_cnt;
    scan(segs4(5, 6, 7, 8), SC, 4, 8, t);
    tests++; if (fv_cnt - f0 !== 1) begin fails++; $display("FAIL exact_dwell_frames: got %0d want 1", fv_cnt - f0); end
    tests++; if (last_fv_cyc !== t + 2 + SC) begin fails++; $display("FAIL exact_dwell_latency: got %0d want %0d", last_fv_cyc - t, 2 + SC); end
    tests++; if (digits !== 16'h8765) begin fails++; $display("FAIL exact_dwell_digits: got %h want 8765", digits); end
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL dwell_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
  endtask

  task automatic test_bad_segment();
    int b0, t;
    logic [27:0] s;
    b0 = bad_cyc;
    s = segs4(1, 2, 0, 4);
    s[14 +: 7] = 7'b1010101;
    scan(s, 8, 4, 6, t);
    tests++; if (digits !== 16'h4E21) begin fails++; $display("FAIL badseg_digits: got %h want 4e21", digits); end
    tests++; if (seg_err !== 4'b0100) begin fails++; $display("FAIL badseg_err: got %b want 0100", seg_err); end
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL badseg_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
  endtask

  task automatic test_anode_glitch();
    int f0, a0, b0, t;
    f0 = fv_cnt; a0 = aerr_cnt; b0 = bad_cyc;
    scan(segs4(3, 1, 4, 0), 8, 3, 0, t);
    drive(4'b0111, pat(9), 3);
    drive(4'b0011, pat(9), 1);
    t = cyc;
    drive(4'b0111, pat(9), 8);
    drive(4'hF, 7'h7F, 6);
    #1;
    tests++; if (aerr_cnt - a0 !== 1) begin fails++; $display("FAIL glitch_aerr: got %0d pulses want 1", aerr_cnt - a0); end
    tests++; if (fv_cnt - f0 !== 1) begin fails++; $display("FAIL glitch_frames: got %0d want 1", fv_cnt - f0); end
    tests++; if (last_fv_cyc !== t + 2 + SC) begin fails++; $display("FAIL glitch_restart: got %0d want %0d", last_fv_cyc - t, 2 + SC); end
    tests++; if (digits !== 16'h9413) begin fails++; $display("FAIL glitch_digits: got %h want 9413", digits); end
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL glitch_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
  endtask

  task automatic test_blank();
    int f0, t;
    f0 = fv_cnt;
    scan({4{7'h7F}}, 8, 4, 6, t);
    tests++; if (fv_cnt - f0 !== 1) begin fails++; $display("FAIL blank_frames: got %0d want 1", fv_cnt - f0); end
    tests++; if (digits !== 16'hFFFF) begin fails++; $display("FAIL blank_digits: got %h want ffff", digits); end
    tests++; if (seg_err !== 4'h0) begin fails++; $display("FAIL blank_seg_err: got %h want 0", seg_err); end
  endtask

  task automatic test_back_to_back();
    int f0, b0, t;
    f0 = fv_cnt; b0 = bad_cyc;
    scan(segs4(2, 4, 6, 8), 5, 4, 0, t);
    scan(segs4(1, 3, 5, 7), 5, 4, 6, t);
    tests++; if (fv_cnt - f0 !== 2) begin fails++; $display("FAIL b2b_frames: got %0d want 2", fv_cnt - f0); end
    tests++; if (digits !== 16'h7531) begin fails++; $display("FAIL b2b_digits: got %h want 7531", digits); end
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL b2b_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
  endtask

  task automatic test_reset_midframe();
    int f0, t;
    f0 = fv_cnt;
    scan(segs4(1, 2, 3, 0), 8, 3, 4, t);
    tests++; if (fv_cnt !== f0) begin fails++; $display("FAIL midframe_partial: got %0d frames want 0", fv_cnt - f0); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL midframe_reset_digits: got %h want 0000", digits); end
    rst = 1'b1;
    drive(4'b0111, pat(8), 8);
    drive(4'hF, 7'h7F, 6);
    #1;
    tests++; if (fv_cnt !== f0) begin fails++; $display("FAIL midframe_stale_mask: got %0d frames want 0", fv_cnt - f0); end
    scan(segs4(5, 6, 7, 0), 8, 3, 6, t);
    tests++; if (fv_cnt - f0 !== 1) begin fails++; $display("FAIL midframe_frames: got %0d want 1", fv_cnt - f0); end
    tests++; if (digits !== 16'h8765) begin fails++; $display("FAIL midframe_digits: got %h want 8765", digits); end
  endtask

  task automatic test_random();
    int b0, f0, e0, a0, x0, r;
    logic [3:0] a;
    logic [6:0] s;
    b0 = bad_cyc; f0 = fv_cnt; e0 = exp_fv_cnt; a0 = aerr_cnt; x0 = exp_aerr_cnt;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin a = 4'hF; a[$urandom_range(0, 3)] = 1'b0; end
      else if (r < 90) a = 4'hF;
      else a = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 80) s = pat($urandom_range(0, 9));
      else if (r < 90) s = 7'h7F;
      else s = 7'($urandom_range(0, 127));
      drive(a, s, $urandom_range(1, 7));
    end
    drive(4'hF, 7'h7F, 8);
    #1;
    tests++; if (bad_cyc !== b0) begin fails++; $display("FAIL random_model: %0d cycles differ from model, want 0", bad_cyc - b0); end
    tests++; if (fv_cnt - f0 !== exp_fv_cnt - e0) begin fails++; $display("FAIL random_frames: got %0d want %0d", fv_cnt - f0, exp_fv_cnt - e0); end
    tests++; if (aerr_cnt - a0 !== exp_aerr_cnt - x0) begin fails++; $display("FAIL random_aerr: got %0d want %0d", aerr_cnt - a0, exp_aerr_cnt - x0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_scan_basic();
    test_dwell();
    test_bad_segment();
    test_anode_glitch();
    test_blank();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_bus_decoder.md
SEG_BUS_DECODER -- requirements
Module: seg_bus_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 16, giving the cycles a digit must stay unchanged before capture (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the stability counter.
REQ-003 The port list SHALL be as follows, clock and reset first:
  clk  input  1  single clock; all logic on rising edge.
  rst  input  1  reset, asynchronous, active-low.
  anode  input  4  active-low digit select from the multiplexed display bus; bit i selects digit i.
  seg  input  7  active-low segments, bit6=a .. bit0=g.
  digits  output  16  decoded frame; digit i on [4i+3:4i].
  frame_valid  output  1  one-cycle pulse when digits updates.
  seg_err  output  4  per-digit unrecognized-pattern flag, updated with digits.
  anode_err  output  1  one-cycle pulse on an illegal anode value.

Function
REQ-004 anode and seg SHALL each pass through a 2-flop synchronizer; all further logic SHALL use the synchronized values (sa, ss).
REQ-005 sa SHALL be valid only when exactly one bit is 0; sa=4'b1111 SHALL be blanking (legal, no capture); any other value SHALL be illegal.
REQ-006 On illegal sa the block SHALL pulse anode_err for one cycle per illegal cycle, clear the stability counter and perform no capture.
REQ-007 The segment decode SHALL be: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank); every other pattern SHALL decode to 4'hE and flag an error.
REQ-008 The FSM SHALL have states IDLE (sa blank or illegal), COUNT (valid sa, counter < STABLE_CNT) and HELD (digit captured, waiting for change).
REQ-009 The counter SHALL load 1 and the FSM SHALL enter COUNT whenever valid {sa,ss} differs from its previous-cycle value; otherwise it SHALL increment in COUNT.
REQ-010 When the counter reaches STABLE_CNT the block SHALL capture the decoded code and error bit into shadow slot i, set capture-mask bit i and enter HELD.
REQ-011 In HELD, unchanged inputs SHALL cause no further capture; any change SHALL go to COUNT (valid) or IDLE (blank/illegal).
REQ-012 Recapturing a slot already in the mask SHALL overwrite the shadow value, keeping only the newest.
REQ-013 On the edge where the mask becomes 4'b1111, digits and seg_err SHALL load all four shadow slots atomically, frame_valid SHALL assert for exactly the following cycle, and the mask SHALL clear.
REQ-014 Output latency SHALL be 2 sync cycles + STABLE_CNT cycles from an input change to the capture edge, and frame_valid SHALL be visible 1 cycle after the capture edge.
REQ-015 digits and seg_err SHALL hold between frames; they SHALL NOT change except as defined in REQ-013.
REQ-016 If a capture and an illegal anode would occur in the same cycle, the illegal condition SHALL win: no capture, and anode_err SHALL pulse.

Reset
REQ-017 While rst=0 the block SHALL asynchronously force sync flops to all ones, the counter, mask and shadow slots to 0, the FSM to IDLE, digits=16'h0000, seg_err=4'h0, frame_valid=0 and anode_err=0.
REQ-018 Reset mid-frame SHALL discard all partial captures; the first frame after release SHALL require four fresh captures.
REQ-019 Reset release SHALL be synchronous to clk in effect: the first counting cycle is the first rising edge with rst=1.

Verification (bench uses STABLE_CNT=4)
REQ-020 Scan digits 0..3 with patterns for 1,2,3,4 and a dwell of 8 cycles each -> one frame_valid pulse, digits=16'h4321, seg_err=0.
REQ-021 Dwell of 3 cycles per digit -> no capture and frame_valid stays 0; raising the dwell to 4 -> capture at exactly 2+4 cycles.
REQ-022 Digit 2 with seg=7'b1010101 -> digits[11:8]=4'hE and seg_err=4'b0100 at frame.
REQ-023 anode=4'b0011 for 1 cycle during a dwell -> one anode_err pulse and a counter restart, so the capture is delayed by the full STABLE_CNT.
REQ-024 Assert rst after 3 of 4 digits are captured, then rescan 5,6,7,8 -> no frame before all four are recaptured, then digits=16'h8765.
REQ-025 All-blank scan (seg=7'b1111111) -> digits=16'hFFFF, seg_err=0.
